axi_apb_bridge: RTL
===================

AXI_APB_BRIDGE -- requirements
Module: axi_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: ACCESS-phase cycles without out_pready before abort.
REQ-002 SHALL have parameter PPROT, default 3'b000: constant driven on out_pprot.
REQ-003 clock  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_awvalid  input  1  AXI4-Lite write-address valid.
REQ-006 in_awready  output  1  write-address accept.
REQ-007 in_awaddr  input  32  write address.
REQ-008 in_wvalid  input  1  write-data valid.
REQ-009 in_wready  output  1  write-data accept.
REQ-010 in_wdata  input  32  write data.
REQ-011 in_wstrb  input  4  write byte strobes.
REQ-012 in_bvalid  output  1  write response valid.
REQ-013 in_bready  input  1  write response accept.
REQ-014 in_bresp  output  2  OKAY=2'b00, SLVERR=2'b10.
REQ-015 in_arvalid  input  1  read-address valid.
REQ-016 in_arready  output  1  read-address accept.
REQ-017 in_araddr  input  32  read address.
REQ-018 in_rvalid  output  1  read data valid.
REQ-019 in_rready  input  1  read data accept.
REQ-020 in_rdata  output  32  read data.
REQ-021 in_rresp  output  2  OKAY/SLVERR.
REQ-022 out_paddr  output  32  APB address.
REQ-023 out_psel  output  1  APB select.
REQ-024 out_penable  output  1  APB enable.
REQ-025 out_pprot  output  3  equals PPROT.
REQ-026 out_pwrite  output  1  1=write.
REQ-027 out_pwdata  output  32  APB write data.
REQ-028 out_pstrb  output  4  byte strobes, 4'b0000 on reads.
REQ-029 out_pready  input  1  APB completer ready.
REQ-030 out_prdata  input  32  APB read data.
REQ-031 out_pslverr  input  1  APB error, sampled with out_pready.

Function
REQ-032 SHALL run FSM IDLE->SETUP->ACCESS->RESP->IDLE, with one transaction outstanding at a time.
REQ-033 IDLE: in_arvalid takes priority, so in_arready pulses 1 cycle and address/type are latched. Otherwise, when in_awvalid&&in_wvalid, in_awready and in_wready pulse together in the same cycle. A write SHALL NOT be accepted while either valid is low.
REQ-034 All in_*ready outputs SHALL be 0 outside the IDLE accept cycle.
REQ-035 SETUP (exactly 1 cycle): out_psel=1, out_penable=0, with address/data/strobe/pwrite stable from latched values.
REQ-036 ACCESS: out_psel=1, out_penable=1, held until out_pready=1 or timeout. APB signals SHALL NOT change while in ACCESS.
REQ-037 On out_pready=1 in ACCESS: latch out_prdata and resp = out_pslverr ? 2'b10 : 2'b00, then drop psel/penable next cycle and enter RESP.
REQ-038 Timeout: a 10-bit+ counter clears on SETUP and increments each ACCESS cycle. When count==TIMEOUT_CYCLES with no out_pready, abort to RESP with resp=2'b10 and rdata=32'h0.
REQ-039 RESP: assert in_rvalid (read) or in_bvalid (write) with latched data/resp, held until the matching ready. The handshake cycle returns to IDLE, so the next accept happens at the earliest 1 cycle later.
REQ-040 Minimum latency with out_pready tied 1: accept cycle, SETUP, ACCESS, RESP, i.e. rvalid/bvalid 3 cycles after the ready pulse.
REQ-041 out_paddr/out_pwdata SHALL pass unmodified. Address decode (flash vs SPI master range) belongs to the downstream completer.
REQ-042 Simultaneous arvalid and awvalid&&wvalid in IDLE: the read is served first, and the write stays pending, accepted on the next IDLE.

Reset
REQ-043 With reset=0 at a clock edge: state=IDLE, and all valid/ready/psel/penable/pwrite = 0, out_paddr/out_pwdata/in_rdata = 0, out_pstrb=0, resp=2'b00, counter=0.
REQ-044 Reset mid-transaction SHALL abandon it with no response generated, and out_psel SHALL drop on the first reset edge.

Verification
REQ-045 Read 0x30000010, out_pready=1, prdata=0xDEADBEEF -> rvalid 3 cycles after arready, rdata=0xDEADBEEF, rresp=00.
REQ-046 Write 0x10001014 data 0x1 strb 4'hF, completer inserts 5 wait states -> penable high 6 cycles, bvalid, bresp=00.
REQ-047 Read with out_pready stuck 0, TIMEOUT_CYCLES=15 -> abort after 15 ACCESS cycles, rresp=10, rdata=0.
REQ-048 arvalid and awvalid+wvalid raised on the same cycle -> read APB phase first, write phase after rready, correct response on each channel.
REQ-049 out_pslverr=1 with pready on a write -> bresp=10. Hold bready low 4 cycles -> bvalid stays high, no new accept.
REQ-050 reset=0 asserted in ACCESS -> psel/penable 0 next edge, no rvalid, and a clean read succeeds after release.

Source files
------------

// File: rtl/axi_apb_bridge.sv
// rtl/axi_apb_bridge.sv - AXI4-Lite to APB bridge, one transaction in flight
// Reads win arbitration in IDLE; ACCESS aborts with SLVERR after TIMEOUT_CYCLES.
module axi_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [2:0]  PPROT          = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_awvalid,
  output logic        in_awready,
  input  logic [31:0] in_awaddr,
  input  logic        in_wvalid,
  output logic        in_wready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  output logic        in_bvalid,
  input  logic        in_bready,
  output logic [1:0]  in_bresp,
  input  logic        in_arvalid,
  output logic        in_arready,
  input  logic [31:0] in_araddr,
  output logic        in_rvalid,
  input  logic        in_rready,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [1:0]    resp;
  logic [31:0]   rdata_q;
  logic          rd_accept;
  logic          wr_accept;

  // Accept is combinational on valid so the handshake completes in the IDLE cycle itself.
  assign rd_accept  = reset && (state == IDLE) && in_arvalid;
  assign wr_accept  = reset && (state == IDLE) && !in_arvalid && in_awvalid && in_wvalid;
  assign in_arready = rd_accept;
  assign in_awready = wr_accept;
  assign in_wready  = wr_accept;

  assign count_next = count + CW'(1);
  assign in_rdata   = rdata_q;
  assign in_rresp   = resp;
  assign in_bresp   = resp;
  assign out_pprot  = PPROT;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      resp        <= 2'b00;
      rdata_q     <= 32'h0;
      out_paddr   <= 32'h0;
      out_pwdata  <= 32'h0;
      out_pstrb   <= 4'h0;
      out_pwrite  <= 1'b0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      in_rvalid   <= 1'b0;
      in_bvalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_accept) begin
            out_paddr  <= in_araddr;
            out_pwdata <= 32'h0;
            out_pstrb  <= 4'h0;
            out_pwrite <= 1'b0;
            out_psel   <= 1'b1;
            state      <= SETUP;
          end else if (wr_accept) begin
            out_paddr  <= in_awaddr;
            out_pwdata <= in_wdata;
            out_pstrb  <= in_wstrb;
            out_pwrite <= 1'b1;
            out_psel   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          out_penable <= 1'b1;
          count       <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          count <= count_next;
          if (out_pready) begin
            rdata_q     <= out_prdata;
            resp        <= out_pslverr ? 2'b10 : 2'b00;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            in_rvalid   <= !out_pwrite;
            in_bvalid   <= out_pwrite;
            state       <= RESP;
          end else if (count_next >= CW'(TIMEOUT_CYCLES)) begin
            // Completer never answered: report SLVERR with zeroed read data.
            rdata_q     <= 32'h0;
            resp        <= 2'b10;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            in_rvalid   <= !out_pwrite;
            in_bvalid   <= out_pwrite;
            state       <= RESP;
          end
        end
        RESP: begin
          if ((in_rvalid && in_rready) || (in_bvalid && in_bready)) begin
            in_rvalid <= 1'b0;
            in_bvalid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
